// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM states and oversampling constants.
package uart_pkg;

  // Oversample ticks per bit period, and the tick index that lands mid-bit.
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } uart_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Receive FIFO: storage, extra-MSB wrap pointers, occupancy flags and a registered pop port.
// A push while full is dropped and reported on overrun_o; full/empty come from registered
// pointers only, so a same-cycle pop never makes room for a push.
module rx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   pop_data_o,
  output logic                    pop_valid_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    overrun_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic                  pop_valid_q, pop_valid_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign pop_data_o  = pop_data_q;
  assign pop_valid_o = pop_valid_q;
  assign overrun_o   = overrun_q;

  // Next pointers, popped word and status pulses.
  always_comb begin
    do_push     = push_i & ~full_o;
    do_pop      = pop_i & ~empty_o;
    wr_ptr_d    = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d    = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    pop_data_d  = do_pop ? mem_q[rd_ptr_q[AddrW-1:0]] : pop_data_q;
    pop_valid_d = do_pop;
    overrun_d   = push_i & full_o;
  end

  // Pointer and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Storage array; no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/uart_rx_read.sv
// UART receiver with a read-side FIFO: synchronizes rxd, oversamples 16x, frames characters
// LSB first and pushes good ones into rx_fifo.
// Optional even-parity bit after the data is enabled by defining UART_RX_PARITY_EN; without it
// the frame is 8N1-style (start, DATA_WIDTH data bits, stop) and parity_err is tied low.
module uart_rx_read
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BAUD_DIV   = 27
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         rxd,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         frame_err,
  output logic                         overrun_err,
  output logic                         parity_err
);

  localparam int unsigned DivW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned SubW = $clog2(OVERSAMPLE);
  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  localparam logic [DivW-1:0] DivLast = DivW'(BAUD_DIV - 1);
  localparam logic [SubW-1:0] SubMid  = SubW'(MID_SAMPLE);
  localparam logic [SubW-1:0] SubLast = SubW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic                  rx_prev_q, rx_prev_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [SubW-1:0]       sub_q, sub_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  push_q, push_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rx_s;
  logic                  tick;
  logic                  start_mid;
  logic                  bit_mid;

  // Synchronized line level seen by all receive logic.
  assign rx_s = sync_q[1];

  assign tick      = (div_q == DivLast);
  // START is sampled halfway into the start bit; later bits a full bit period apart.
  assign start_mid = tick && (sub_q == SubMid);
  assign bit_mid   = tick && (sub_q == SubLast);

`ifdef UART_RX_PARITY_EN
  logic parity_err_q, parity_err_d;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign frame_err = frame_err_q;

  // Frame decoder next state: divider, tick sub-counter, bit counter, shifter and pulses.
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rxd};
    rx_prev_d   = rx_s;
    div_d       = tick ? '0 : div_q + DivW'(1);
    sub_d       = sub_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s) begin
          // Realign the divider to the start edge so sample points are fixed to the frame.
          state_d = StStart;
          div_d   = '0;
          sub_d   = '0;
        end
      end

      StStart: begin
        if (start_mid) begin
          sub_d   = '0;
          cnt_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end else if (tick) begin
          sub_d = sub_q + SubW'(1);
        end
      end

      StData: begin
        if (bit_mid) begin
          sub_d   = '0;
          shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else if (tick) begin
          sub_d = sub_q + SubW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (bit_mid) begin
          sub_d        = '0;
          // Even parity: data bits plus parity bit must hold an even number of ones.
          parity_err_d = (rx_s != (^shift_q));
          state_d      = StStop;
        end else if (tick) begin
          sub_d = sub_q + SubW'(1);
        end
      end
`endif

      StStop: begin
        if (bit_mid) begin
          sub_d = '0;
          if (rx_s) begin
            push_d  = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end
        end else if (tick) begin
          sub_d = sub_q + SubW'(1);
        end
      end

      StWaitIdle: begin
        // A held-low line (break) must return high before another start is accepted.
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Receive-side registers; reset abandons any partial character.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      sync_q      <= 2'b11;
      rx_prev_q   <= 1'b1;
      div_q       <= '0;
      sub_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      div_q       <= div_d;
      sub_q       <= sub_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // The shifter is stable while push_q is high, so it feeds the FIFO directly.
  rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push_q),
    .push_data_i (shift_q),
    .pop_i       (rd_en),
    .pop_data_o  (rd_data),
    .pop_valid_o (rd_valid),
    .empty_o     (empty),
    .full_o      (full),
    .level_o     (level),
    .overrun_o   (overrun_err)
  );

endmodule

// File: tb/tb_uart_rx_read.sv
// Bench for uart_rx_read: directed vector table, hand sequences for glitch/break/overflow/
// reset corners, and a random send/read mix checked against a queue model of the FIFO.
module tb_uart_rx_read;

  localparam int BAUD  = 4;
  localparam int BIT   = 16 * BAUD;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, empty, full, frame_err, overrun_err, parity_err;
  logic [4:0] level;

  always #5 clk = ~clk;

  uart_rx_read #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (DEPTH),
    .BAUD_DIV   (BAUD)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rxd         (rxd),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .level       (level),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun_err === 1'b1) ov_cnt++;
    if (parity_err === 1'b1) pe_cnt++;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd = bits[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  // One frame, correct parity when parity is built in; a low stop bit can be stretched.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int tail_low);
    logic [15:0] b;
    int n;
`ifdef UART_RX_PARITY_EN
    b = {5'b0, stop, ^d, d, 1'b0};
    n = 11;
`else
    b = {6'b0, stop, d, 1'b0};
    n = 10;
`endif
    @(negedge clk);
    send_bits(b, n);
    if (!stop) repeat (tail_low * BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic do_read(output logic v, output logic [7:0] d, output logic v_after);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    v = rd_valid;
    d = rd_data;
    @(negedge clk);
    v_after = rd_valid;
  endtask

  typedef struct {
    bit         is_read;
    logic [7:0] data;
    bit         stop;
    bit         exp_valid;
    logic [7:0] exp_data;
    int         exp_level;
    int         exp_fe;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] mq[$];

  initial begin
    logic       v, va;
    logic [7:0] d, last_rd, exp_d;
    int fe0, ov0, pe0, exp_fe, exp_ov, lat;

    vecs[0] = '{is_read: 0, data: 8'hA5, stop: 1, exp_valid: 0, exp_data: 8'h00, exp_level: 1, exp_fe: 0};
    vecs[1] = '{is_read: 1, data: 8'h00, stop: 1, exp_valid: 1, exp_data: 8'hA5, exp_level: 0, exp_fe: 0};
    vecs[2] = '{is_read: 0, data: 8'h3C, stop: 0, exp_valid: 0, exp_data: 8'h00, exp_level: 0, exp_fe: 1};
    vecs[3] = '{is_read: 0, data: 8'h5A, stop: 1, exp_valid: 0, exp_data: 8'h00, exp_level: 1, exp_fe: 0};
    vecs[4] = '{is_read: 0, data: 8'hC3, stop: 1, exp_valid: 0, exp_data: 8'h00, exp_level: 2, exp_fe: 0};
    vecs[5] = '{is_read: 1, data: 8'h00, stop: 1, exp_valid: 1, exp_data: 8'h5A, exp_level: 1, exp_fe: 0};
    vecs[6] = '{is_read: 1, data: 8'h00, stop: 1, exp_valid: 1, exp_data: 8'hC3, exp_level: 0, exp_fe: 0};
    vecs[7] = '{is_read: 1, data: 8'h00, stop: 1, exp_valid: 0, exp_data: 8'hC3, exp_level: 0, exp_fe: 0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_pulses", {frame_err, overrun_err, parity_err}, 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      fe0 = fe_cnt;
      if (vecs[i].is_read) begin
        do_read(v, d, va);
        chk($sformatf("v%0d_valid", i), v, vecs[i].exp_valid);
        chk($sformatf("v%0d_data", i), d, vecs[i].exp_data);
        chk($sformatf("v%0d_valid_after", i), va, 0);
      end else begin
        send_frame(vecs[i].data, vecs[i].stop, 0);
      end
      chk($sformatf("v%0d_level", i), level, vecs[i].exp_level);
      chk($sformatf("v%0d_empty", i), empty, vecs[i].exp_level == 0);
      chk($sformatf("v%0d_frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
    end
    last_rd = 8'hC3;

    // Start glitch of 5 ticks: rejected silently, receiver still usable.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    @(negedge clk);
    rxd = 1'b0;
    repeat (5 * BAUD) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("glitch_level", level, 0);
    chk("glitch_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    send_frame(8'h81, 1, 0);
    chk("glitch_after_level", level, 1);
    do_read(v, d, va);
    chk("glitch_after_data", d, 8'h81);

    // Break: bad stop bit then line low for 40 bit times -> a single frame error.
    fe0 = fe_cnt;
    send_frame(8'h3C, 0, 40);
    repeat (BIT) @(negedge clk);
    chk("break_frame_err", fe_cnt - fe0, 1);
    chk("break_level", level, 0);
    send_frame(8'h96, 1, 0);
    do_read(v, d, va);
    chk("break_recover", {v, d}, {1'b1, 8'h96});

    // Fill to full; measure frame-start-to-push latency on the first char.
    ov0 = ov_cnt;
    lat = 0;
    fork
      send_frame(8'h00, 1, 0);
      begin
        @(negedge clk);
        while (level == 0 && lat < 2000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("push_latency_bound", lat < 2000, 1);
    for (int i = 1; i <= 16; i++) begin
      send_frame(8'(i), 1, 0);
      chk($sformatf("fill%0d_full", i), full, i >= 15);
    end
    chk("fill_overrun", ov_cnt - ov0, 1);
    chk("fill_level", level, 16);

    // Pop lands in the same cycle as a push into the full FIFO.
    ov0 = ov_cnt;
    fork
      send_frame(8'h11, 1, 0);
      begin
        repeat (lat) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        v = rd_valid;
        d = rd_data;
      end
    join
    chk("same_cycle_pop", {v, d}, {1'b1, 8'h00});
    chk("same_cycle_overrun", ov_cnt - ov0, 1);
    chk("same_cycle_level", level, 15);
    for (int i = 1; i < 16; i++) begin
      do_read(v, d, va);
      chk($sformatf("drain%0d", i), {v, d}, {1'b1, 8'(i)});
    end
    chk("drain_empty", empty, 1);
    last_rd = 8'h0F;

    exp_fe = 0;
    exp_ov = 0;
    pe0 = pe_cnt;
`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so a parity bit of 0 is wrong; character still stored.
    @(negedge clk);
    send_bits({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
    chk("parity_err_pulse", pe_cnt - pe0, 1);
    chk("parity_level", level, 1);
    do_read(v, d, va);
    chk("parity_data", d, 8'h07);
    last_rd = 8'h07;
    pe0 = pe_cnt;
`endif

    // Random mix against a queue model.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) < 2) begin
        logic [7:0] rd8;
        bit good;
        rd8  = 8'($urandom_range(0, 255));
        good = ($urandom_range(0, 7) != 0);
        send_frame(rd8, good, 0);
        if (!good) exp_fe++;
        else if (mq.size() < DEPTH) mq.push_back(rd8);
        else exp_ov++;
      end else begin
        do_read(v, d, va);
        if (mq.size() > 0) begin
          exp_d = mq.pop_front();
          chk($sformatf("rnd%0d_read", i), {v, d}, {1'b1, exp_d});
          last_rd = exp_d;
        end else begin
          chk($sformatf("rnd%0d_read_empty", i), {v, d}, {1'b0, last_rd});
        end
      end
      chk($sformatf("rnd%0d_level", i), level, mq.size());
      chk($sformatf("rnd%0d_full", i), full, mq.size() == DEPTH);
    end
    chk("rnd_frame_errs", fe_cnt - fe0, exp_fe);
    chk("rnd_overruns", ov_cnt - ov0, exp_ov);
    chk("rnd_parity_quiet", pe_cnt - pe0, 0);
    while (mq.size() > 0) begin
      exp_d = mq.pop_front();
      do_read(v, d, va);
      chk("rnd_drain", {v, d}, {1'b1, exp_d});
    end

    // Reset in the middle of a frame with data buffered.
    send_frame(8'h42, 1, 0);
    @(negedge clk);
    rxd = 1'b0;
    repeat (5 * BIT) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_level", level, 0);
    chk("midrst_flags", {empty, full, rd_valid}, 3'b100);
    chk("midrst_rd_data", rd_data, 0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    pe0 = pe_cnt;
    repeat (12 * BIT) @(negedge clk);
    chk("midrst_no_push", level, 0);
    chk("midrst_no_errs", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);
    send_frame(8'h24, 1, 0);
    do_read(v, d, va);
    chk("midrst_recover", {v, d, va}, {1'b1, 8'h24, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_read.md
UART_RX_READ -- requirements
Module: uart_rx_read

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per character.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of 2).
REQ-003 SHALL have parameter BAUD_DIV, default 27, clk cycles per 16x oversample tick (minimum 1).
REQ-004 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rxd  input  1  serial line, asynchronous, idle high.
REQ-007 SHALL have port rd_en  input  1  pop request from consumer.
REQ-008 SHALL have port rd_data  output  DATA_WIDTH  popped character, registered.
REQ-009 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data updated.
REQ-010 SHALL have port empty  output  1  FIFO holds no characters.
REQ-011 SHALL have port full  output  1  FIFO holds FIFO_DEPTH characters.
REQ-012 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-014 SHALL have port overrun_err  output  1  one-cycle pulse, character dropped on full FIFO.
REQ-015 SHALL have port parity_err  output  1  one-cycle pulse, parity mismatch (see Configuration).

Function
REQ-016 SHALL pass rxd through a 2-flop synchronizer before any use; rxd-to-FSM latency 2 cycles.
REQ-017 SHALL generate a tick every BAUD_DIV cycles from a free-running divider, restarted when FSM leaves IDLE.
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-019 IDLE -> START on synchronized rxd high-to-low; tick sub-counter cleared.
REQ-020 START: at sub-count 7 (mid-bit), rxd low -> DATA; rxd high -> IDLE (glitch rejected, no error).
REQ-021 DATA: sample every 16 ticks at mid-bit, LSB first, into shift register; after DATA_WIDTH samples -> PARITY if enabled, else STOP.
REQ-022 STOP: mid-bit sample high -> push character, IDLE; low -> frame_err pulse, character discarded, WAIT_IDLE.
REQ-023 WAIT_IDLE -> IDLE only after synchronized rxd is high (break condition yields one frame_err only).
REQ-024 Push with full asserted SHALL drop the character and pulse overrun_err; FIFO contents unchanged.
REQ-025 Full is evaluated from registered state: push and pop in same cycle while full -> push dropped, pop performed.
REQ-026 Push and pop in same cycle while neither full nor empty -> both performed, level unchanged.
REQ-027 rd_en with empty SHALL be ignored: no pointer change, rd_valid low, rd_data held.
REQ-028 rd_en with !empty SHALL update rd_data and pulse rd_valid on the next rising edge.
REQ-029 Pointers SHALL be $clog2(FIFO_DEPTH)+1 bits, wrap naturally; full when MSBs differ and low bits equal; empty when equal.

Reset
REQ-030 On rstn low: FSM IDLE, synchronizer flops 1, divider/counters 0, pointers 0, rd_data 0, all pulses 0, empty 1, full 0, level 0.
REQ-031 Reset mid-frame SHALL abandon the partial character; no push, no error pulse after release.

Configuration
REQ-032 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit after data; mismatch pulses parity_err and character is still pushed.
REQ-033 Macro undefined: no PARITY state, DATA -> STOP directly, parity_err tied 0.

Structure
REQ-034 Package uart_pkg SHALL hold FSM state enum, OVERSAMPLE=16 and MID_SAMPLE=7 constants, shared with the TX path.
REQ-035 FIFO SHALL be a sub-module rx_fifo (storage, pointers, full/empty/level); FSM and sampling in uart_rx_read.

Verification
REQ-036 BAUD_DIV=4, send 0xA5 (8N1) -> rd_en after empty falls gives rd_data=0xA5, rd_valid 1 cycle, level 1->0.
REQ-037 rxd low pulse of 5 ticks then high -> no push, no error, FSM back to IDLE.
REQ-038 Send 0x3C with stop bit 0 -> frame_err single pulse, level stays 0; line held low 40 bits -> no further frame_err.
REQ-039 Send 17 characters 0x00..0x10 without reads -> full after 16th, overrun_err on 17th, reads return 0x00..0x0F in order.
REQ-040 Full FIFO, rd_en asserted in push cycle -> pushed byte dropped, overrun_err 1, level 15.
REQ-041 UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulse, rd_data=0x07 on read.
